// File: rtl/leiwand_rv32_timer_pkg.sv
// Shared constants and helpers for the leiwand_rv32 machine timer.
// Register offsets are word indices taken from i_addr[4:2].
package leiwand_rv32_timer_pkg;

    localparam int MEM_WIDTH = 32;

    localparam logic [2:0] TIMER_REG_MTIME_LO    = 3'd0;
    localparam logic [2:0] TIMER_REG_MTIME_HI    = 3'd1;
    localparam logic [2:0] TIMER_REG_MTIMECMP_LO = 3'd2;
    localparam logic [2:0] TIMER_REG_MTIMECMP_HI = 3'd3;
    localparam logic [2:0] TIMER_REG_PRESCALE    = 3'd4;

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } timer_state_e;

    // Replace only the byte lanes whose write enable is set.
    function automatic logic [MEM_WIDTH-1:0] merge_bytes(
        input logic [MEM_WIDTH-1:0] old_val,
        input logic [MEM_WIDTH-1:0] wdata,
        input logic [3:0]           wen
    );
        logic [MEM_WIDTH-1:0] result;
        result = old_val;
        for (int b = 0; b < 4; b++) begin
            if (wen[b]) result[8*b +: 8] = wdata[8*b +: 8];
        end
        return result;
    endfunction

endpackage

// File: rtl/leiwand_rv32_timer_prescaler.sv
// Reload down-counter: o_tick is high while the count is zero, then the count
// reloads. A load forces the new reload value in immediately.
module leiwand_rv32_timer_prescaler #(
    parameter logic [31:0] PRESCALE_RESET = 32'd0
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_load,
    input  logic [31:0] i_reload,
    output logic        o_tick
);

    logic [31:0] count;

    assign o_tick = (count == 32'd0);

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            count <= PRESCALE_RESET;
        end else if (i_load || o_tick) begin
            count <= i_reload;
        end else begin
            count <= count - 32'd1;
        end
    end

endmodule

// File: rtl/leiwand_rv32_timer.sv
// Memory-mapped RISC-V machine timer (mtime/mtimecmp) on a valid/ready bus.
// Define LEIWAND_RV32_TIMER_PRESCALER_EN to add the PRESCALE register and tick divider.
module leiwand_rv32_timer
    import leiwand_rv32_timer_pkg::*;
#(
    parameter logic [63:0] MTIMECMP_RESET = 64'hFFFF_FFFF_FFFF_FFFF
`ifdef LEIWAND_RV32_TIMER_PRESCALER_EN
    ,
    parameter logic [31:0] PRESCALE_RESET = 32'd0
`endif
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic [MEM_WIDTH-1:0] i_addr,
    input  logic [MEM_WIDTH-1:0] i_wdata,
    input  logic [3:0]           i_wen,
    output logic [MEM_WIDTH-1:0] o_rdata,
    output logic                 o_timer_irq
);

    timer_state_e   state, state_next;
    logic [63:0]    mtime, mtime_next, mtime_inc;
    logic [63:0]    mtimecmp, mtimecmp_next;
    logic [31:0]    rd_val;
    logic [2:0]     offset;
    logic           access, wr, tick;

    // Address bits outside [4:2] are decoded by the SoC, not here.
    logic unused_addr;
    assign unused_addr = &{1'b0, i_addr[31:5], i_addr[1:0]};

    assign offset = i_addr[4:2];
    assign access = (state == IDLE) && i_valid;
    assign wr     = access && (i_wen != 4'b0000);

`ifdef LEIWAND_RV32_TIMER_PRESCALER_EN
    logic [31:0] prescale, prescale_next;
    logic        prescale_wr;

    assign prescale_wr   = wr && (offset == TIMER_REG_PRESCALE);
    assign prescale_next = prescale_wr ? merge_bytes(prescale, i_wdata, i_wen) : prescale;

    leiwand_rv32_timer_prescaler #(
        .PRESCALE_RESET (PRESCALE_RESET)
    ) u_prescaler (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_load   (prescale_wr),
        .i_reload (prescale_next),
        .o_tick   (tick)
    );

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) prescale <= PRESCALE_RESET;
        else        prescale <= prescale_next;
    end
`else
    assign tick = 1'b1;
`endif

    assign mtime_inc = mtime + {63'd0, tick};

    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        mtime_next    = mtime_inc;
        mtimecmp_next = mtimecmp;
        if (wr) begin
            // Written bytes override the tick; the other half keeps the incremented value.
            case (offset)
                TIMER_REG_MTIME_LO:
                    mtime_next = {mtime_inc[63:32], merge_bytes(mtime_inc[31:0], i_wdata, i_wen)};
                TIMER_REG_MTIME_HI:
                    mtime_next = {merge_bytes(mtime_inc[63:32], i_wdata, i_wen), mtime_inc[31:0]};
                TIMER_REG_MTIMECMP_LO:
                    mtimecmp_next = {mtimecmp[63:32], merge_bytes(mtimecmp[31:0], i_wdata, i_wen)};
                TIMER_REG_MTIMECMP_HI:
                    mtimecmp_next = {merge_bytes(mtimecmp[63:32], i_wdata, i_wen), mtimecmp[31:0]};
                default: ;
            endcase
        end
    end

    always_comb begin
        rd_val = 32'd0;
        case (offset)
            TIMER_REG_MTIME_LO:    rd_val = mtime[31:0];
            TIMER_REG_MTIME_HI:    rd_val = mtime[63:32];
            TIMER_REG_MTIMECMP_LO: rd_val = mtimecmp[31:0];
            TIMER_REG_MTIMECMP_HI: rd_val = mtimecmp[63:32];
`ifdef LEIWAND_RV32_TIMER_PRESCALER_EN
            TIMER_REG_PRESCALE:    rd_val = prescale;
`endif
            default:               rd_val = 32'd0;
        endcase
    end

    // FSM: state register
    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) state <= IDLE;
        else        state <= state_next;
    end

    // FSM: next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (i_valid) state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        o_ready = (state == RESP);
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            mtime       <= 64'd0;
            mtimecmp    <= MTIMECMP_RESET;
            o_rdata     <= '0;
            o_timer_irq <= 1'b0;
        end else begin
            mtime       <= mtime_next;
            mtimecmp    <= mtimecmp_next;
            o_timer_irq <= (mtime >= mtimecmp);
            if (access) o_rdata <= rd_val;
        end
    end

endmodule

// File: tb/tb_leiwand_rv32_timer.sv
// Self-checking bench for leiwand_rv32_timer: directed scenarios plus random
// bus traffic against a time-based model of mtime/mtimecmp.
module tb_leiwand_rv32_timer;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b0;
    logic        i_valid = 1'b0;
    logic [31:0] i_addr = '0;
    logic [31:0] i_wdata = '0;
    logic [3:0]  i_wen = '0;
    logic        o_ready;
    logic [31:0] o_rdata;
    logic        o_timer_irq;

    int checks = 0;
    int failures = 0;

    leiwand_rv32_timer dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_valid     (i_valid),
        .o_ready     (o_ready),
        .i_addr      (i_addr),
        .i_wdata     (i_wdata),
        .i_wen       (i_wen),
        .o_rdata     (o_rdata),
        .o_timer_irq (o_timer_irq)
    );

    always #5 i_clk = ~i_clk;

    // Rising edges seen since reset was last released.
    longint unsigned edges;
    always @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) edges <= 0;
        else        edges <= edges + 1;
    end

    // Model: mtime equals m_base right after edge m_base_edge and then counts one per edge.
    logic [63:0]     m_base;
    longint unsigned m_base_edge;
    logic [63:0]     m_cmp;
    logic [31:0]     m_prescale;
    bit              m_free;

    function automatic logic [63:0] mtime_at(input longint unsigned n);
        return m_base + 64'(n - m_base_edge);
    endfunction

    function automatic logic [31:0] lane_merge(input logic [31:0] old_val, input logic [31:0] wdata,
                                               input logic [3:0] wen);
        logic [31:0] mask;
        mask = {{8{wen[3]}}, {8{wen[2]}}, {8{wen[1]}}, {8{wen[0]}}};
        return (old_val & ~mask) | (wdata & mask);
    endfunction

    task automatic model_reset();
        m_base      = 64'd0;
        m_base_edge = 0;
        m_cmp       = 64'hFFFF_FFFF_FFFF_FFFF;
        m_prescale  = 32'd0;
        m_free      = 1'b1;
    endtask

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called at a negedge at least one edge after the last register write.
    task automatic check_irq(input string tag);
        logic [63:0] cur;
        cur = mtime_at(edges - 1);
        check(tag, o_timer_irq, m_free ? (cur >= m_cmp) : 1'b0);
    endtask

    // One bus transaction, started and finished on a negedge (consumes two edges).
    task automatic bus(input logic [2:0] off, input logic [31:0] wdata, input logic [3:0] wen,
                       output logic [31:0] rd);
        longint unsigned n;
        logic [63:0] cur, inc;
        logic [31:0] exp_rd;
        logic        exp_irq;
        n   = edges;
        cur = mtime_at(n);
        case (off)
            3'd0: exp_rd = cur[31:0];
            3'd1: exp_rd = cur[63:32];
            3'd2: exp_rd = m_cmp[31:0];
            3'd3: exp_rd = m_cmp[63:32];
`ifdef LEIWAND_RV32_TIMER_PRESCALER_EN
            3'd4: exp_rd = m_prescale;
`endif
            default: exp_rd = 32'd0;
        endcase
        exp_irq = m_free ? (cur >= m_cmp) : 1'b0;
        check("ready_before", o_ready, 1'b0);
        i_valid = 1'b1;
        i_addr  = ($urandom() & 32'hFFFF_FFE0) | {27'd0, off, 2'b00} | ($urandom() & 32'h3);
        i_wdata = wdata;
        i_wen   = wen;
        @(posedge i_clk);
        @(negedge i_clk);
        check("ready_pulse", o_ready, 1'b1);
        if (m_free || off > 3'd1) check("rdata", o_rdata, exp_rd);
        check("irq_access", o_timer_irq, exp_irq);
        rd = o_rdata;
        if (wen != 4'b0000) begin
            inc = cur + 64'd1;
            case (off)
                3'd0: begin m_base = {inc[63:32], lane_merge(inc[31:0], wdata, wen)}; m_base_edge = n + 1; end
                3'd1: begin m_base = {lane_merge(inc[63:32], wdata, wen), inc[31:0]}; m_base_edge = n + 1; end
                3'd2: m_cmp = {m_cmp[63:32], lane_merge(m_cmp[31:0], wdata, wen)};
                3'd3: m_cmp = {lane_merge(m_cmp[63:32], wdata, wen), m_cmp[31:0]};
`ifdef LEIWAND_RV32_TIMER_PRESCALER_EN
                3'd4: m_prescale = lane_merge(m_prescale, wdata, wen);
`endif
                default: ;
            endcase
        end
        i_valid = 1'b0;
        i_wen   = 4'b0000;
        @(posedge i_clk);
        @(negedge i_clk);
        check("ready_after", o_ready, 1'b0);
        check_irq("irq_after");
    endtask

    logic [31:0] rd, r1, r2;
    int          pulses;
    logic [63:0] now;

    initial begin
        model_reset();
        repeat (3) @(negedge i_clk);
        check("reset_ready", o_ready, 1'b0);
        check("reset_rdata", o_rdata, 32'd0);
        check("reset_irq", o_timer_irq, 1'b0);
        i_rst = 1'b1;

        // Reset value of mtimecmp
        bus(3'd3, 32'd0, 4'b0000, rd);
        check("cmp_hi_reset", rd, 32'hFFFF_FFFF);

        // Low-to-high carry
        bus(3'd1, 32'd0, 4'b1111, rd);
        bus(3'd0, 32'hFFFF_FFFE, 4'b1111, rd);
        repeat (3) @(negedge i_clk);
        bus(3'd1, 32'd0, 4'b0000, rd);
        check("carry_hi", rd, 32'h0000_0001);

        // Interrupt rises one cycle after mtime reaches mtimecmp, falls after cmp raised
        bus(3'd1, 32'd0, 4'b1111, rd);
        bus(3'd3, 32'd0, 4'b1111, rd);
        now = mtime_at(edges);
        bus(3'd2, now[31:0] + 32'd12, 4'b1111, rd);
        for (int i = 0; i < 20; i++) begin
            @(negedge i_clk);
            check_irq("irq_track");
        end
        check("irq_high", o_timer_irq, 1'b1);
        bus(3'd3, 32'd1, 4'b1111, rd);
        check("irq_fell", o_timer_irq, 1'b0);

        // Partial byte write while counting
        bus(3'd0, 32'h0000_00AA, 4'b0001, rd);
        bus(3'd0, 32'd0, 4'b0000, rd);
        check("byte0_kept", rd[7:0], 8'hAA + 8'd1);

        // Unmapped offsets
        bus(3'd6, 32'h1234_5678, 4'b1111, rd);
        check("unmapped_18", rd, 32'd0);
`ifndef LEIWAND_RV32_TIMER_PRESCALER_EN
        bus(3'd4, 32'h1234_5678, 4'b1111, rd);
        bus(3'd4, 32'd0, 4'b0000, rd);
        check("unmapped_10", rd, 32'd0);
`endif

        // Held valid gives a response every other cycle
        pulses = 0;
        i_valid = 1'b1;
        i_addr  = 32'h0000_0000;
        i_wen   = 4'b0000;
        for (int i = 0; i < 6; i++) begin
            @(posedge i_clk);
            @(negedge i_clk);
            if (o_ready) pulses++;
        end
        i_valid = 1'b0;
        check("hold_pulses", pulses, 3);
        @(negedge i_clk);

        // Random traffic
        for (int t = 0; t < 80; t++) begin
            logic [2:0]  off;
            logic [3:0]  wen;
            off = 3'($urandom_range(0, 7));
`ifdef LEIWAND_RV32_TIMER_PRESCALER_EN
            if (off == 3'd4) off = 3'd5;
`endif
            wen = ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'($urandom_range(0, 15));
            bus(off, $urandom(), wen, rd);
            repeat ($urandom_range(0, 2)) begin
                @(negedge i_clk);
                check_irq("irq_gap");
            end
        end

`ifdef LEIWAND_RV32_TIMER_PRESCALER_EN
        // Prescaler: start from reset so mtimecmp keeps the interrupt low
        @(negedge i_clk);
        i_rst = 1'b0;
        @(negedge i_clk);
        i_rst = 1'b1;
        model_reset();
        bus(3'd4, 32'd3, 4'b1111, rd);
        m_free = 1'b0;
        bus(3'd4, 32'd0, 4'b0000, rd);
        check("prescale_rd", rd, 32'd3);
        bus(3'd0, 32'd0, 4'b0000, r1);
        repeat (38) @(negedge i_clk);
        bus(3'd0, 32'd0, 4'b0000, r2);
        check("prescale_rate", r2 - r1, 32'd10);
`endif

        // Reset asserted while the response is pending
        i_valid = 1'b1;
        i_addr  = 32'h0000_0004;
        i_wen   = 4'b0000;
        @(posedge i_clk);
        #1 i_rst = 1'b0;
        #1;
        check("rst_ready", o_ready, 1'b0);
        check("rst_rdata", o_rdata, 32'd0);
        check("rst_irq", o_timer_irq, 1'b0);
        @(negedge i_clk);
        i_valid = 1'b0;
        i_rst   = 1'b1;
        model_reset();
        bus(3'd0, 32'd0, 4'b0000, rd);
        check("rst_mtime", rd, 32'd0);
`ifdef LEIWAND_RV32_TIMER_PRESCALER_EN
        bus(3'd4, 32'd0, 4'b0000, rd);
        check("rst_prescale", rd, 32'd0);
`endif
        bus(3'd0, 32'd0, 4'b0000, rd);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
